// File: rtl/rr_fwd_stage.sv
// Register-read pipeline stage: holds one decoded instruction with its operands,
// forwarding later-stage results into the operands at capture and while stalled.
module rr_fwd_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int RADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            pc,
  input  logic [RADDR_W-1:0]         rs1_number,
  input  logic [RADDR_W-1:0]         rs2_number,
  input  logic [RADDR_W-1:0]         rd_number,
  input  logic [XLEN-1:0]            immediate,
  input  logic [6:0]                 func7,
  input  logic [2:0]                 func3,
  input  logic [6:0]                 opcode,
  input  logic [XLEN-1:0]            a_val,
  input  logic [XLEN-1:0]            b_val,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            pc_out,
  output logic [RADDR_W-1:0]         rs1_number_out,
  output logic [RADDR_W-1:0]         rs2_number_out,
  output logic [XLEN-1:0]            rs1_val_out,
  output logic [XLEN-1:0]            rs2_val_out,
  output logic [RADDR_W-1:0]         rd_number_out,
  output logic [XLEN-1:0]            immediate_out,
  output logic [6:0]                 func7_out,
  output logic [2:0]                 func3_out,
  output logic [6:0]                 opcode_out
);

  logic               valid_q, valid_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [RADDR_W-1:0] rs1_q, rs1_d;
  logic [RADDR_W-1:0] rs2_q, rs2_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic [6:0]         f7_q, f7_d;
  logic [2:0]         f3_q, f3_d;
  logic [6:0]         op_q, op_d;
  logic [XLEN-1:0]    v1_q, v1_d;
  logic [XLEN-1:0]    v2_q, v2_d;

  logic               capture;
  logic [RADDR_W-1:0] sel_rs1, sel_rs2;
  logic [XLEN-1:0]    base_v1, base_v2;
  logic [XLEN-1:0]    res_v1, res_v2;

  // Iterating from the oldest source down lets the youngest match overwrite last.
  function automatic logic [XLEN-1:0] resolve(
    input logic [RADDR_W-1:0]         rs,
    input logic [XLEN-1:0]            v,
    input logic [NUM_FWD-1:0]         fv,
    input logic [NUM_FWD*RADDR_W-1:0] frd,
    input logic [NUM_FWD*XLEN-1:0]    fdat
  );
    logic [XLEN-1:0] r;
    r = v;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fv[i] && (frd[i*RADDR_W +: RADDR_W] == rs) && (rs != '0)) begin
        r = fdat[i*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // One resolver per operand: fed by the incoming instruction on capture,
  // otherwise by the held entry so stalled operands keep snooping.
  assign sel_rs1 = capture ? rs1_number : rs1_q;
  assign sel_rs2 = capture ? rs2_number : rs2_q;
  assign base_v1 = capture ? a_val : v1_q;
  assign base_v2 = capture ? b_val : v2_q;
  assign res_v1  = resolve(sel_rs1, base_v1, fwd_valid, fwd_rd, fwd_data);
  assign res_v2  = resolve(sel_rs2, base_v2, fwd_valid, fwd_rd, fwd_data);

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    f7_d    = f7_q;
    f3_d    = f3_q;
    op_d    = op_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      pc_d    = pc;
      rs1_d   = rs1_number;
      rs2_d   = rs2_number;
      rd_d    = rd_number;
      imm_d   = immediate;
      f7_d    = func7;
      f3_d    = func3;
      op_d    = opcode;
      v1_d    = res_v1;
      v2_d    = res_v2;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      v1_d = res_v1;
      v2_d = res_v2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      f7_q    <= '0;
      f3_q    <= '0;
      op_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      f7_q    <= f7_d;
      f3_q    <= f3_d;
      op_q    <= op_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
    end
  end

  assign out_valid      = valid_q;
  assign pc_out         = pc_q;
  assign rs1_number_out = rs1_q;
  assign rs2_number_out = rs2_q;
  assign rd_number_out  = rd_q;
  assign immediate_out  = imm_q;
  assign func7_out      = f7_q;
  assign func3_out      = f3_q;
  assign opcode_out     = op_q;
  assign rs1_val_out    = v1_q;
  assign rs2_val_out    = v2_q;

endmodule

// File: tb/tb_rr_fwd_stage.sv
// Bench for rr_fwd_stage: a reference model checked every cycle, directed
// scenarios with literal expectations, and a 64-bit single-source instance.
module tb_rr_fwd_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] pc, immediate, a_val, b_val;
  logic [4:0]  rs1_number, rs2_number, rd_number;
  logic [6:0]  func7, opcode;
  logic [2:0]  func3;
  logic [2:0]  fwd_valid;
  logic [14:0] fwd_rd;
  logic [95:0] fwd_data;
  logic [31:0] pc_out, rs1_val_out, rs2_val_out, immediate_out;
  logic [4:0]  rs1_number_out, rs2_number_out, rd_number_out;
  logic [6:0]  func7_out, opcode_out;
  logic [2:0]  func3_out;

  // 64-bit, single forwarding source instance
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [63:0] w_pc, w_imm, w_a, w_b, w_fdata;
  logic [4:0]  w_rs1, w_rs2, w_rd, w_frd;
  logic [0:0]  w_fvalid;
  logic [63:0] w_pc_out, w_v1_out, w_v2_out, w_imm_out;
  logic [4:0]  w_rs1_out, w_rs2_out, w_rd_out;
  logic [6:0]  w_f7_out, w_op_out;
  logic [2:0]  w_f3_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_fwd_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .rs1_number(rs1_number), .rs2_number(rs2_number), .rd_number(rd_number),
    .immediate(immediate), .func7(func7), .func3(func3), .opcode(opcode),
    .a_val(a_val), .b_val(b_val), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .rs1_number_out(rs1_number_out), .rs2_number_out(rs2_number_out),
    .rs1_val_out(rs1_val_out), .rs2_val_out(rs2_val_out), .rd_number_out(rd_number_out),
    .immediate_out(immediate_out), .func7_out(func7_out), .func3_out(func3_out),
    .opcode_out(opcode_out)
  );

  rr_fwd_stage #(.XLEN(64), .NUM_FWD(1), .RADDR_W(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .pc(w_pc), .rs1_number(w_rs1), .rs2_number(w_rs2), .rd_number(w_rd),
    .immediate(w_imm), .func7(7'h21), .func3(3'h5), .opcode(7'h13),
    .a_val(w_a), .b_val(w_b), .fwd_valid(w_fvalid), .fwd_rd(w_frd),
    .fwd_data(w_fdata), .flush(1'b0), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .pc_out(w_pc_out), .rs1_number_out(w_rs1_out), .rs2_number_out(w_rs2_out),
    .rs1_val_out(w_v1_out), .rs2_val_out(w_v2_out), .rd_number_out(w_rd_out),
    .immediate_out(w_imm_out), .func7_out(w_f7_out), .func3_out(w_f3_out),
    .opcode_out(w_op_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_valid;
  logic [31:0] m_pc, m_imm, m_v1, m_v2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [6:0]  m_f7, m_op;
  logic [2:0]  m_f3;

  // First matching source in priority order wins; x0 is never forwarded.
  function automatic logic [31:0] ref_resolve(input logic [4:0] r, input logic [31:0] v);
    if (r == 5'd0) return v;
    for (int i = 0; i < 3; i++) begin
      if (fwd_valid[i] && fwd_rd[i*5 +: 5] == r) return fwd_data[i*32 +: 32];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0; m_pc <= '0; m_imm <= '0; m_v1 <= '0; m_v2 <= '0;
      m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_f7 <= '0; m_op <= '0; m_f3 <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_pc <= pc; m_imm <= immediate; m_rs1 <= rs1_number; m_rs2 <= rs2_number;
      m_rd <= rd_number; m_f7 <= func7; m_f3 <= func3; m_op <= opcode;
      m_v1 <= ref_resolve(rs1_number, a_val);
      m_v2 <= ref_resolve(rs2_number, b_val);
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end else if (m_valid) begin
      m_v1 <= ref_resolve(m_rs1, m_v1);
      m_v2 <= ref_resolve(m_rs2, m_v2);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      if (m_valid) begin
        chk("pc_out", {32'd0, pc_out}, {32'd0, m_pc});
        chk("imm_out", {32'd0, immediate_out}, {32'd0, m_imm});
        chk("rs1_val", {32'd0, rs1_val_out}, {32'd0, m_v1});
        chk("rs2_val", {32'd0, rs2_val_out}, {32'd0, m_v2});
        chk("fields", {35'd0, rs1_number_out, rs2_number_out, rd_number_out, func7_out, func3_out, opcode_out},
            {35'd0, m_rs1, m_rs2, m_rd, m_f7, m_f3, m_op});
      end
    end
  end

  // One clock: through the rising edge, to the falling edge where checks happen.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_fwd(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    fwd_valid[i] = v;
    fwd_rd[i*5 +: 5] = rd;
    fwd_data[i*32 +: 32] = d;
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; flush = 0; out_ready = 0;
    pc = 0; immediate = 0; a_val = 0; b_val = 0;
    rs1_number = 0; rs2_number = 0; rd_number = 0;
    func7 = 0; func3 = 0; opcode = 0;
    fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
    w_in_valid = 0; w_out_ready = 0; w_pc = 0; w_imm = 0; w_a = 0; w_b = 0;
    w_fdata = 0; w_rs1 = 0; w_rs2 = 0; w_rd = 0; w_frd = 0; w_fvalid = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_pc_out", {32'd0, pc_out}, 64'd0);

    // reset mid-stream
    in_valid = 1; pc = 32'h100; rd_number = 5'd9; func7 = 7'h20; func3 = 3'h2; opcode = 7'h33;
    tick();
    in_valid = 0;
    chk("mid_pc", {32'd0, pc_out}, 64'h100);
    chk("mid_valid", {63'd0, out_valid}, 64'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_pc", {32'd0, pc_out}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_rd", {59'd0, rd_number_out}, 64'd0);

    // back-to-back
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; pc = 32'(k * 4); immediate = 32'h1000 + 32'(k);
      tick();
      chk("b2b_pc", {32'd0, pc_out}, 64'(k * 4));
      chk("b2b_valid", {63'd0, out_valid}, 64'd1);
    end

    // forwarding priority
    rs1_number = 5; a_val = 32'h11; rs2_number = 6; b_val = 32'h66;
    set_fwd(0, 1, 5, 32'hAA); set_fwd(1, 1, 5, 32'hBB); set_fwd(2, 0, 0, 0);
    tick();
    chk("prio_rs1", {32'd0, rs1_val_out}, 64'hAA);
    chk("prio_rs2_nomatch", {32'd0, rs2_val_out}, 64'h66);
    rs1_number = 0;
    set_fwd(0, 1, 0, 32'hAA); set_fwd(1, 1, 0, 32'hBB);
    tick();
    chk("x0_rs1", {32'd0, rs1_val_out}, 64'h11);
    rs1_number = 5; rs2_number = 5; b_val = 32'h22;
    set_fwd(0, 0, 5, 32'hAA); set_fwd(1, 1, 5, 32'hBB);
    tick();
    chk("same_rs1", {32'd0, rs1_val_out}, 64'hBB);
    chk("same_rs2", {32'd0, rs2_val_out}, 64'hBB);
    set_fwd(1, 0, 0, 0); set_fwd(2, 1, 5, 32'hCC);
    tick();
    chk("src2_rs1", {32'd0, rs1_val_out}, 64'hCC);
    set_fwd(2, 0, 0, 0);

    // stall snoop
    rs1_number = 1; rs2_number = 7; a_val = 32'h3; b_val = 32'h1; pc = 32'h180;
    tick();
    chk("snoop_cap", {32'd0, rs2_val_out}, 64'h1);
    out_ready = 0; pc = 32'h200;
    tick();
    chk("snoop_ready0", {63'd0, in_ready}, 64'd0);
    chk("snoop_hold_pc", {32'd0, pc_out}, 64'h180);
    set_fwd(2, 1, 7, 32'h55);
    tick();
    chk("snoop_rs2", {32'd0, rs2_val_out}, 64'h55);
    chk("snoop_rs1", {32'd0, rs1_val_out}, 64'h3);
    set_fwd(2, 0, 0, 0);
    tick();
    chk("snoop_keep", {32'd0, rs2_val_out}, 64'h55);
    chk("snoop_ready0b", {63'd0, in_ready}, 64'd0);
    in_valid = 0; out_ready = 1;
    tick();
    chk("drain_valid", {63'd0, out_valid}, 64'd0);

    // flush with incoming
    in_valid = 1; pc = 32'h300;
    tick();
    out_ready = 0; pc = 32'h400; flush = 1;
    tick();
    flush = 0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_nocap", {32'd0, pc_out}, 64'h300);
    pc = 32'h500;
    tick();
    chk("post_flush_pc", {32'd0, pc_out}, 64'h500);
    chk("post_flush_valid", {63'd0, out_valid}, 64'd1);

    // short mixed handshake run, model-checked
    for (int k = 0; k < 12; k++) begin
      in_valid = k[0]; out_ready = k[1] | k[2]; flush = (k == 9);
      pc = 32'h600 + 32'(k * 4); rs1_number = 5'(k); rs2_number = 5'(k + 1);
      a_val = 32'(k * 3); b_val = 32'(k * 5);
      set_fwd(1, k[1], 5'(k), 32'hF00 + 32'(k));
      tick();
    end
    in_valid = 0; flush = 0; fwd_valid = 0; out_ready = 1;
    tick();

    // 64-bit, single source
    w_in_valid = 1; w_out_ready = 1; w_pc = 64'h8000_0000_0000_0010;
    w_imm = 64'hFFFF_FFFF_0000_0001; w_rs1 = 3; w_rs2 = 4; w_a = 64'h1234; w_b = 64'h5678;
    w_fvalid = 1; w_frd = 3; w_fdata = 64'hDEAD_BEEF_0000_0042;
    tick();
    chk("w_imm", w_imm_out, 64'hFFFF_FFFF_0000_0001);
    chk("w_rs1_fwd", w_v1_out, 64'hDEAD_BEEF_0000_0042);
    chk("w_rs2_reg", w_v2_out, 64'h5678);
    chk("w_pc", w_pc_out, 64'h8000_0000_0000_0010);
    w_frd = 4;
    tick();
    chk("w_rs1_reg", w_v1_out, 64'h1234);
    chk("w_rs2_fwd", w_v2_out, 64'hDEAD_BEEF_0000_0042);
    w_in_valid = 0;
    tick();
    chk("w_drain", {63'd0, w_out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_fwd_stage.md
Name: rr_fwd_stage

Overview:
Parametrised register-read pipeline stage between decode/regfile read and execute.
- Captures decoded fields and register-file operands under a valid/ready handshake.
- Resolves RAW hazards by forwarding from NUM_FWD later-stage result buses, both at capture and while an entry is held stalled.
- Supports flush for branch redirect. Output-side field set matches what the execute stage consumes.

Parameters:
XLEN, 32, data/PC/immediate width
NUM_FWD, 3, number of forwarding sources; index 0 = youngest (highest priority)
RADDR_W, 5, register-number width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts this cycle
pc  in  XLEN  instruction PC
rs1_number  in  RADDR_W  source 1 register
rs2_number  in  RADDR_W  source 2 register
rd_number  in  RADDR_W  destination register
immediate  in  XLEN  decoded immediate
func7  in  7  funct7
func3  in  3  funct3
opcode  in  7  opcode
a_val  in  XLEN  regfile read of rs1
b_val  in  XLEN  regfile read of rs2
fwd_valid  in  NUM_FWD  per-source result valid (writes a register)
fwd_rd  in  NUM_FWD*RADDR_W  per-source destination, source i at [i*RADDR_W +: RADDR_W]
fwd_data  in  NUM_FWD*XLEN  per-source result, source i at [i*XLEN +: XLEN]
flush  in  1  kill held and incoming instruction
out_valid  out  1  held entry valid
out_ready  in  1  execute accepts held entry
pc_out  out  XLEN  registered PC
rs1_number_out  out  RADDR_W  registered rs1 number
rs2_number_out  out  RADDR_W  registered rs2 number
rs1_val_out  out  XLEN  resolved rs1 operand
rs2_val_out  out  XLEN  resolved rs2 operand
rd_number_out  out  RADDR_W  registered rd
immediate_out  out  XLEN  registered immediate
func7_out  out  7  registered funct7
func3_out  out  3  registered funct3
opcode_out  out  7  registered opcode

Behaviour:
- Reset (sync, active-high, on posedge clk): every output register is 0, including out_valid. Reset overrides flush and capture. in_ready is combinational and therefore 1 after reset.
- in_ready = !out_valid || out_ready. Combinational, independent of flush.
- Capture: on posedge with in_valid && in_ready && !flush, all *_out fields load from inputs and out_valid <= 1. Latency is 1 cycle.
- Drain: out_ready && out_valid with no capture leaves out_valid <= 0. Data fields hold their last values.
- Flush: out_valid <= 0 next cycle, regardless of out_ready. Any same-cycle incoming instruction is dropped. Data fields are don't-care and are held.
- Forward resolve for operand rsX with regfile value v:
  - Take the lowest index i such that fwd_valid[i] && fwd_rd[i] == rsX && rsX != 0, and use fwd_data[i].
  - If no such i, use v.
  - rsX == 0 always yields v. No forwarding to x0.
- At capture: rs1_val_out/rs2_val_out <= resolve(rs1_number, a_val) / resolve(rs2_number, b_val).
- Stalled snoop: while out_valid && !out_ready && !flush, each cycle rs1_val_out <= resolve(rs1_number_out, rs1_val_out), and likewise for rs2. This captures results that retire while the entry waits. Other fields hold.
- rs1 == rs2: both operands resolve identically from the same source.
- Simultaneous drain+capture (out_valid && out_ready && in_valid): the new entry loads and out_valid stays 1. No bubble, full throughput.
- Pure combinational paths: in_ready and the resolve muxes only. All outputs except in_ready are registered.

Test Plan:
- Reset mid-stream: hold out_valid=1 with pc_out=0x100, assert reset 1 cycle -> all outputs 0, out_valid=0, in_ready=1.
- Back-to-back: in_valid=1, out_ready=1, pc=0x0,0x4,0x8 on three cycles -> pc_out 0x0,0x4,0x8 one cycle later each, out_valid continuously 1.
- Priority forward: rs1=5, a_val=0x11, fwd_valid=3'b011, fwd_rd[0]=fwd_rd[1]=5, fwd_data[0]=0xAA, fwd_data[1]=0xBB -> rs1_val_out=0xAA. Repeat with rs1=0 -> 0x11.
- Stall snoop: capture rs2=7, b_val=0x1; out_ready=0 for 3 cycles; cycle 2 fwd_valid[2]=1, fwd_rd[2]=7, fwd_data[2]=0x55 -> rs2_val_out=0x55 from the next cycle on, in_ready=0 throughout; out_ready=1 then drains it.
- Flush with incoming: out_valid=1, out_ready=0, in_valid=1, flush=1 -> next cycle out_valid=0 and the incoming pc is not captured; the following cycle accepts normally.
- Parameter sweep: XLEN=64, NUM_FWD=1 -> 64-bit immediate 0xFFFF_FFFF_0000_0001 passes unchanged; the single source forwards correctly.
